// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC level decoder: FSM states,
// the level-code width and the escape prefixes.
package cavlc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_REQ,
        S_CALC,
        S_OUT,
        S_FIN
    } state_t;

    localparam int SUFFIX_MAX_DEFAULT = 6;

    localparam logic [3:0] ESC_PREFIX      = 4'd14;
    localparam logic [3:0] ESC_PREFIX_LONG = 4'd15;

    typedef logic [13:0] level_code_t;

    // Number of level_suffix bits the parser has to pull for this prefix.
    function automatic logic [3:0] suffix_bits(input logic [3:0] prefix, input logic [2:0] suffix_len);
        if (prefix == ESC_PREFIX_LONG)
            return 4'd12;
        else if (prefix == ESC_PREFIX && suffix_len == 3'd0)
            return 4'd4;
        else
            return {1'b0, suffix_len};
    endfunction

endpackage

// File: rtl/cavlc_level_decoder_if.sv
// Code-in / level-out channels of the level decoder.
// Both channels use valid/ready: a transfer happens on a rising Clk edge where
// valid and ready are both high; the source holds payload and valid until then.
interface cavlc_level_decoder_if #(parameter int LEVEL_W = 13);
    logic                      CodeValid;
    logic                      CodeReady;
    logic [3:0]                LevelPrefix;
    logic [11:0]               LevelSuffix;
    logic [3:0]                SuffixBits;
    logic                      LevelValid;
    logic                      LevelReady;
    logic signed [LEVEL_W-1:0] LevelOut;
    logic [3:0]                LevelIdx;

    // master: parser + downstream stage; slave: the decoder
    modport master (
        output CodeValid, LevelPrefix, LevelSuffix, LevelReady,
        input  CodeReady, SuffixBits, LevelValid, LevelOut, LevelIdx
    );

    modport slave (
        input  CodeValid, LevelPrefix, LevelSuffix, LevelReady,
        output CodeReady, SuffixBits, LevelValid, LevelOut, LevelIdx
    );
endinterface

// File: rtl/cavlc_level_calc.sv
// Combinational level-code arithmetic: prefix/suffix to signed level, plus the
// adapted suffixLength for the next level.
module cavlc_level_calc
    import cavlc_pkg::*;
#(
    parameter int LEVEL_W    = 13,
    parameter int SUFFIX_MAX = SUFFIX_MAX_DEFAULT
) (
    input  logic [3:0]                prefix,
    input  logic [11:0]               suffix,
    input  logic [2:0]                suffix_len,
    input  logic                      first,
    input  logic                      t1_lt3,
    output logic signed [LEVEL_W-1:0] level,
    output logic [2:0]                next_suffix_len
);
    level_code_t        level_code;
    logic [13:0]        magnitude;
    logic signed [15:0] signed_level;
    logic [2:0]         sl_base;
    logic [13:0]        threshold;

    always_comb begin
        level_code = (level_code_t'(prefix) << suffix_len) + level_code_t'(suffix);
        if (prefix == ESC_PREFIX_LONG && suffix_len == 3'd0)
            level_code = level_code + 14'd15;
        if (first && t1_lt3)
            level_code = level_code + 14'd2;

        // Even codes map to positive levels, odd codes to negative.
        if (level_code[0])
            magnitude = 14'(({1'b0, level_code} + 15'd1) >> 1);
        else
            magnitude = 14'(({1'b0, level_code} + 15'd2) >> 1);
        signed_level = {2'b00, magnitude};
        if (level_code[0])
            signed_level = -signed_level;
        level = LEVEL_W'(signed_level);

        // The escalation threshold is taken against the already-bumped length.
        sl_base         = (suffix_len == 3'd0) ? 3'd1 : suffix_len;
        threshold       = 14'd3 << (sl_base - 3'd1);
        next_suffix_len = sl_base;
        if (magnitude > threshold && int'(sl_base) < SUFFIX_MAX)
            next_suffix_len = sl_base + 3'd1;
    end
endmodule

// File: rtl/cavlc_level_decoder.sv
// CAVLC level decoder for one residual block: emits trailing +/-1 levels, then
// decodes prefix/suffix codes into levels while tracking suffixLength.
module cavlc_level_decoder
    import cavlc_pkg::*;
#(
    parameter int LEVEL_W    = 13,
    parameter int MAX_COEFF  = 16,
    parameter int SUFFIX_MAX = SUFFIX_MAX_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  Flush,
    input  logic                  Start,
    input  logic [4:0]            TotalCoeff,
    input  logic [1:0]            TrailingOnes,
    input  logic [2:0]            T1Signs,
    output logic                  Busy,
    output logic                  Done,
    cavlc_level_decoder_if.slave  bus,
    output state_t                fsm_state
);
    state_t                    state;
    logic [4:0]                tc;
    logic [1:0]                t1;
    logic [2:0]                signs;
    logic [3:0]                idx;
    logic [2:0]                suffix_len;
    logic [3:0]                prefix_q;
    logic [11:0]               suffix_q;
    logic [4:0]                tc_clamped;
    logic [1:0]                t1_clamped;
    logic signed [LEVEL_W-1:0] calc_level;
    logic [2:0]                calc_next_sl;

    assign tc_clamped = (TotalCoeff > 5'(MAX_COEFF)) ? 5'(MAX_COEFF) : TotalCoeff;
    assign t1_clamped = ({3'b000, TrailingOnes} > tc_clamped) ? tc_clamped[1:0] : TrailingOnes;

    assign bus.SuffixBits = (state == S_REQ) ? suffix_bits(bus.LevelPrefix, suffix_len) : 4'd0;
    assign fsm_state      = state;

    cavlc_level_calc #(.LEVEL_W(LEVEL_W), .SUFFIX_MAX(SUFFIX_MAX)) u_calc (
        .prefix          (prefix_q),
        .suffix          (suffix_q),
        .suffix_len      (suffix_len),
        .first           (idx == {2'b00, t1}),
        .t1_lt3          (t1 != 2'd3),
        .level           (calc_level),
        .next_suffix_len (calc_next_sl)
    );

    function automatic logic [LEVEL_W-1:0] t1_level(input logic neg);
        return neg ? {LEVEL_W{1'b1}} : LEVEL_W'(1);
    endfunction

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state          <= S_IDLE;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            bus.CodeReady  <= 1'b0;
            bus.LevelValid <= 1'b0;
            bus.LevelOut   <= '0;
            bus.LevelIdx   <= 4'd0;
            tc             <= 5'd0;
            t1             <= 2'd0;
            signs          <= 3'd0;
            idx            <= 4'd0;
            suffix_len     <= 3'd0;
            prefix_q       <= 4'd0;
            suffix_q       <= 12'd0;
        end else if (Flush) begin
            state          <= S_IDLE;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            bus.CodeReady  <= 1'b0;
            bus.LevelValid <= 1'b0;
            bus.LevelOut   <= '0;
            bus.LevelIdx   <= 4'd0;
            idx            <= 4'd0;
            suffix_len     <= 3'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: if (Start) begin
                    tc           <= tc_clamped;
                    t1           <= t1_clamped;
                    signs        <= T1Signs;
                    idx          <= 4'd0;
                    bus.LevelIdx <= 4'd0;
                    suffix_len   <= (tc_clamped > 5'd10 && t1_clamped != 2'd3) ? 3'd1 : 3'd0;
                    if (tc_clamped == 5'd0) begin
                        state <= S_FIN;
                        Done  <= 1'b1;
                    end else begin
                        Busy <= 1'b1;
                        if (t1_clamped != 2'd0) begin
                            state          <= S_T1;
                            bus.LevelValid <= 1'b1;
                            bus.LevelOut   <= t1_level(T1Signs[0]);
                        end else begin
                            state         <= S_REQ;
                            bus.CodeReady <= 1'b1;
                        end
                    end
                end
                S_T1: if (bus.LevelReady) begin
                    idx <= idx + 4'd1;
                    if (idx == {2'b00, t1} - 4'd1) begin
                        bus.LevelValid <= 1'b0;
                        if (tc == {3'b000, t1}) begin
                            state <= S_FIN;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            state         <= S_REQ;
                            bus.CodeReady <= 1'b1;
                        end
                    end else begin
                        bus.LevelIdx <= idx + 4'd1;
                        bus.LevelOut <= t1_level(signs[idx[1:0] + 2'd1]);
                    end
                end
                S_REQ: if (bus.CodeValid) begin
                    prefix_q      <= bus.LevelPrefix;
                    suffix_q      <= bus.LevelSuffix;
                    bus.CodeReady <= 1'b0;
                    state         <= S_CALC;
                end
                S_CALC: begin
                    bus.LevelOut   <= calc_level;
                    bus.LevelIdx   <= idx;
                    bus.LevelValid <= 1'b1;
                    suffix_len     <= calc_next_sl;
                    state          <= S_OUT;
                end
                S_OUT: if (bus.LevelReady) begin
                    bus.LevelValid <= 1'b0;
                    idx            <= idx + 4'd1;
                    if ({1'b0, idx} + 5'd1 == tc) begin
                        state <= S_FIN;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state         <= S_REQ;
                        bus.CodeReady <= 1'b1;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cavlc_level_decoder.sv
// Bench for cavlc_level_decoder: directed blocks from the H.264 level tables,
// backpressure, flush, async reset and random blocks against a reference model.
module tb_cavlc_level_decoder;
    import cavlc_pkg::*;

    localparam int LEVEL_W    = 13;
    localparam int MAX_COEFF  = 16;
    localparam int SUFFIX_MAX = 6;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       Flush = 1'b0;
    logic       Start = 1'b0;
    logic [4:0] TotalCoeff = 5'd0;
    logic [1:0] TrailingOnes = 2'd0;
    logic [2:0] T1Signs = 3'd0;
    logic       Busy;
    logic       Done;
    state_t     fsm_state;

    cavlc_level_decoder_if #(.LEVEL_W(LEVEL_W)) bus ();

    cavlc_level_decoder #(.LEVEL_W(LEVEL_W), .MAX_COEFF(MAX_COEFF), .SUFFIX_MAX(SUFFIX_MAX)) dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .Flush        (Flush),
        .Start        (Start),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .T1Signs      (T1Signs),
        .Busy         (Busy),
        .Done         (Done),
        .bus          (bus),
        .fsm_state    (fsm_state)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [LEVEL_W+3:0] exp_q[$];
    logic [3:0]  code_pfx[16];
    logic [11:0] code_sfx[16];
    bit rand_ready = 1'b0;

    // Reference: level_code -> level per the standard's level decoding.
    function automatic int model_level(input int pfx, input int sfx, input int sl, input bit first_lt3);
        int code;
        code = pfx * (1 << sl) + sfx;
        if (pfx == 15 && sl == 0) code = code + 15;
        if (first_lt3) code = code + 2;
        if (code % 2 == 0) return (code + 2) / 2;
        return -((code + 1) / 2);
    endfunction

    // One clock: sample at negedge, drain scoreboard on a level transfer, return after posedge.
    task automatic tick(output bit code_hs, output bit lv, output bit cr, output logic [3:0] sb);
        logic [LEVEL_W+3:0] e;
        @(negedge Clk);
        code_hs = bus.CodeValid && bus.CodeReady;
        lv      = bus.LevelValid;
        cr      = bus.CodeReady;
        sb      = bus.SuffixBits;
        if (bus.LevelValid && bus.LevelReady) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL level_extra: got idx=%0d level=%0d, required no level", bus.LevelIdx, bus.LevelOut);
            end else begin
                e = exp_q.pop_front();
                if ({bus.LevelIdx, bus.LevelOut} !== e) begin
                    miscompares++;
                    $display("FAIL level_value: got idx=%0d level=%0d, required idx=%0d level=%0d",
                             bus.LevelIdx, bus.LevelOut, e[LEVEL_W+3:LEVEL_W], $signed(e[LEVEL_W-1:0]));
                end
            end
        end
        if (Done) done_cnt++;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_block(input int tc_in, input int t1_in, input logic [2:0] signs, input int n_codes);
        int tc, t1, sl, ci, d0, it, hs_it, extra_cr, lvl, mag;
        bit hs, lv, cr, lat_pend;
        logic [3:0] sb;
        logic [3:0] exp_sb[16];
        logic [LEVEL_W-1:0] exp_lvl;
        tc = (tc_in > MAX_COEFF) ? MAX_COEFF : tc_in;
        t1 = (t1_in > tc) ? tc : t1_in;
        sl = (tc > 10 && t1 < 3) ? 1 : 0;
        for (int i = 0; i < t1; i++) begin
            exp_lvl = LEVEL_W'(signs[i] ? -1 : 1);
            exp_q.push_back({4'(i), exp_lvl});
        end
        for (int i = 0; i < n_codes; i++) begin
            exp_sb[i] = (code_pfx[i] == 15) ? 4'd12 : (code_pfx[i] == 14 && sl == 0) ? 4'd4 : 4'(sl);
            code_sfx[i] = code_sfx[i] & 12'((1 << exp_sb[i]) - 1);
            lvl = model_level(int'(code_pfx[i]), int'(code_sfx[i]), sl, (i == 0 && t1 < 3));
            exp_lvl = LEVEL_W'(lvl);
            exp_q.push_back({4'(t1 + i), exp_lvl});
            if (sl == 0) sl = 1;
            mag = (lvl < 0) ? -lvl : lvl;
            if (mag > 3 * (1 << (sl - 1)) && sl < SUFFIX_MAX) sl++;
        end
        TotalCoeff   = 5'(tc_in);
        TrailingOnes = 2'(t1_in);
        T1Signs      = signs;
        Start        = 1'b1;
        tick(hs, lv, cr, sb);
        Start = 1'b0;
        vectors++;
        if (Busy !== (tc > 0)) begin
            miscompares++;
            $display("FAIL busy_after_start: got %b, required %b (tc=%0d)", Busy, (tc > 0), tc);
        end
        d0 = done_cnt; ci = 0; it = 0; hs_it = 0; extra_cr = 0; lat_pend = 1'b0;
        while (done_cnt == d0 && it < 400) begin
            bus.CodeValid = (ci < n_codes);
            if (ci < n_codes) begin
                bus.LevelPrefix = code_pfx[ci];
                bus.LevelSuffix = code_sfx[ci];
            end
            bus.LevelReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(hs, lv, cr, sb);
            it++;
            if (cr && ci >= n_codes) extra_cr++;
            if (lat_pend && lv) begin
                lat_pend = 1'b0;
                vectors++;
                if (it - hs_it != 2) begin
                    miscompares++;
                    $display("FAIL code_to_level_latency: got %0d cycles, required 2", it - hs_it);
                end
            end
            if (hs) begin
                vectors++;
                if (sb !== exp_sb[ci]) begin
                    miscompares++;
                    $display("FAIL suffix_bits: code %0d prefix=%0d got %0d, required %0d", ci, code_pfx[ci], sb, exp_sb[ci]);
                end
                lat_pend = 1'b1;
                hs_it = it;
                ci++;
            end
        end
        bus.CodeValid  = 1'b0;
        bus.LevelReady = 1'b1;
        vectors++;
        if (done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL block_done: got %0d Done pulses, required 1 (tc=%0d t1=%0d)", done_cnt - d0, tc_in, t1_in);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL levels_missing: got %0d still expected, required 0", exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (extra_cr != 0) begin
            miscompares++;
            $display("FAIL code_ready_extra: got %0d cycles with CodeReady, required 0", extra_cr);
        end
    endtask

    task automatic test_reset();
        bit hs, lv, cr;
        logic [3:0] sb;
        nReset = 1'b0;
        bus.CodeValid = 1'b0; bus.LevelPrefix = 4'd14; bus.LevelSuffix = 12'd0; bus.LevelReady = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        vectors++;
        if ({Busy, Done, bus.CodeReady, bus.LevelValid, bus.LevelOut, bus.LevelIdx, bus.SuffixBits} !== '0
            || fsm_state !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b cr=%b lv=%b out=%0d idx=%0d sb=%0d state=%0d, required all 0",
                     Busy, Done, bus.CodeReady, bus.LevelValid, bus.LevelOut, bus.LevelIdx, bus.SuffixBits, fsm_state);
        end
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        tick(hs, lv, cr, sb);
    endtask

    task automatic test_t1_only();
        run_block(3, 3, 3'b010, 0);
    endtask

    task automatic test_basic_levels();
        code_pfx[0] = 4'd0; code_sfx[0] = 12'd0;
        run_block(1, 0, 3'b000, 1);
        code_pfx[0] = 4'd1; code_sfx[0] = 12'd0;
        run_block(1, 0, 3'b000, 1);
    endtask

    task automatic test_escape14();
        code_pfx[0] = 4'd14; code_sfx[0] = 12'd5;
        run_block(2, 1, 3'b000, 1);
        // Second code exposes the escalated suffixLength of 2 through SuffixBits.
        code_pfx[0] = 4'd14; code_sfx[0] = 12'd5;
        code_pfx[1] = 4'd1;  code_sfx[1] = 12'd3;
        run_block(3, 1, 3'b001, 2);
    endtask

    task automatic test_escape15();
        code_pfx[0] = 4'd15; code_sfx[0] = 12'd100;
        for (int i = 1; i < 12; i++) begin
            code_pfx[i] = 4'($urandom_range(0, 15));
            code_sfx[i] = 12'($urandom_range(0, 4095));
        end
        run_block(12, 0, 3'b000, 12);
    endtask

    task automatic test_boundaries();
        run_block(1, 3, 3'b001, 0);
        for (int i = 0; i < 16; i++) begin
            code_pfx[i] = 4'($urandom_range(0, 15));
            code_sfx[i] = 12'($urandom_range(0, 4095));
        end
        run_block(20, 0, 3'b000, 16);
    endtask

    task automatic test_backpressure();
        bit hs, lv, cr;
        logic [3:0] sb;
        exp_q.push_back({4'd0, 13'sd3});
        TotalCoeff = 5'd1; TrailingOnes = 2'd0; Start = 1'b1;
        bus.LevelReady = 1'b0;
        tick(hs, lv, cr, sb);
        Start = 1'b0;
        bus.CodeValid = 1'b1; bus.LevelPrefix = 4'd2; bus.LevelSuffix = 12'd0;
        tick(hs, lv, cr, sb);
        bus.CodeValid = 1'b0;
        tick(hs, lv, cr, sb);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.LevelValid !== 1'b1 || bus.LevelOut !== 13'sd3 || bus.CodeReady !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable: cycle %0d got lv=%b out=%0d cr=%b, required lv=1 out=3 cr=0",
                         i, bus.LevelValid, bus.LevelOut, bus.CodeReady);
            end
            Start = (i == 2); TotalCoeff = 5'd0;
            tick(hs, lv, cr, sb);
        end
        Start = 1'b0;
        bus.LevelReady = 1'b1;
        tick(hs, lv, cr, sb);
        vectors++;
        if (bus.LevelValid !== 1'b0 || Done !== 1'b1) begin
            miscompares++;
            $display("FAIL release_done: got lv=%b done=%b, required lv=0 done=1", bus.LevelValid, Done);
        end
        tick(hs, lv, cr, sb);
        vectors++;
        if (Done !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL release_single: got done=%b pending=%0d, required done=0 pending=0", Done, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_flush();
        bit hs, lv, cr;
        logic [3:0] sb;
        int d0;
        TotalCoeff = 5'd2; TrailingOnes = 2'd0; Start = 1'b1;
        tick(hs, lv, cr, sb);
        Start = 1'b0;
        vectors++;
        if (bus.CodeReady !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_in_req: got CodeReady=%b, required 1", bus.CodeReady);
        end
        Flush = 1'b1;
        tick(hs, lv, cr, sb);
        Flush = 1'b0;
        vectors++;
        if ({Busy, bus.CodeReady, bus.LevelValid, Done} !== 4'b0000 || fsm_state !== S_IDLE) begin
            miscompares++;
            $display("FAIL flush_idle: got busy=%b cr=%b lv=%b done=%b state=%0d, required 0 0 0 0 IDLE",
                     Busy, bus.CodeReady, bus.LevelValid, Done, fsm_state);
        end
        d0 = done_cnt;
        repeat (3) tick(hs, lv, cr, sb);
        vectors++;
        if (done_cnt != d0) begin
            miscompares++;
            $display("FAIL flush_no_done: got %0d Done pulses, required 0", done_cnt - d0);
        end
        TotalCoeff = 5'd0; Start = 1'b1;
        tick(hs, lv, cr, sb);
        Start = 1'b0;
        vectors++;
        if (Done !== 1'b1 || bus.LevelValid !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_block_done: got done=%b lv=%b busy=%b, required 1 0 0", Done, bus.LevelValid, Busy);
        end
        tick(hs, lv, cr, sb);
        vectors++;
        if (Done !== 1'b0 || lv) begin
            miscompares++;
            $display("FAIL empty_block_pulse: got done=%b lv=%b, required 0 0", Done, lv);
        end
    endtask

    task automatic test_async_reset();
        bit hs, lv, cr;
        logic [3:0] sb;
        TotalCoeff = 5'd3; TrailingOnes = 2'd1; T1Signs = 3'b001; Start = 1'b1;
        bus.LevelReady = 1'b0;
        tick(hs, lv, cr, sb);
        Start = 1'b0;
        vectors++;
        if (bus.LevelValid !== 1'b1 || bus.LevelOut !== -13'sd1) begin
            miscompares++;
            $display("FAIL t1_before_reset: got lv=%b out=%0d, required lv=1 out=-1", bus.LevelValid, bus.LevelOut);
        end
        #2 nReset = 1'b0;
        #1;
        vectors++;
        if ({Busy, Done, bus.CodeReady, bus.LevelValid, bus.LevelOut, bus.LevelIdx} !== '0 || fsm_state !== S_IDLE) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b lv=%b out=%0d state=%0d, required all 0",
                     Busy, bus.LevelValid, bus.LevelOut, fsm_state);
        end
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        bus.LevelReady = 1'b1;
    endtask

    task automatic test_random();
        int tc, t1;
        rand_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            tc = $urandom_range(0, 16);
            t1 = $urandom_range(0, (tc < 3) ? tc : 3);
            for (int i = 0; i < 16; i++) begin
                code_pfx[i] = 4'($urandom_range(0, 15));
                code_sfx[i] = 12'($urandom_range(0, 4095));
            end
            run_block(tc, t1, 3'($urandom_range(0, 7)), tc - t1);
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_t1_only();
        test_basic_levels();
        test_escape14();
        test_escape15();
        test_boundaries();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cavlc_level_decoder.md
Name: cavlc_level_decoder

Overview:
Parametrised CAVLC level decoder for one residual block. It accepts TotalCoeff, TrailingOnes and trailing-one signs, emits the trailing ±1 levels, then decodes each remaining level_prefix/level_suffix pair into a signed level. It adapts suffixLength internally and tells the bitstream parser how many suffix bits to read. It sits between the coeff_token/prefix parser and the run/zero placement stage, and owns both level-code arithmetic and suffixLength tracking.

Parameters:
LEVEL_W, 13, signed output level width (min 13)
MAX_COEFF, 16, max TotalCoeff per block (16 luma/AC, 4 chroma DC)
SUFFIX_MAX, 6, ceiling for suffixLength adaptation

Ports:
Clk  in  1  clock
nReset  in  1  reset, asynchronous, active-low
Flush  in  1  synchronous abort; returns to IDLE next cycle
Start  in  1  block start pulse; sampled only in IDLE
TotalCoeff  in  5  number of nonzero coeffs, 0..MAX_COEFF
TrailingOnes  in  2  0..3, must be <= TotalCoeff
T1Signs  in  3  bit i = sign of i-th trailing one (1 = negative)
Busy  out  1  high from accepted Start until Done
SuffixBits  out  4  level_suffix length the parser must read for the current prefix
CodeValid  in  1  LevelPrefix/LevelSuffix valid
CodeReady  out  1  decoder accepts a code
LevelPrefix  in  4  level_prefix, 0..15
LevelSuffix  in  12  level_suffix, right-justified
LevelValid  out  1  LevelOut valid
LevelReady  in  1  downstream accepts
LevelOut  out  LEVEL_W  signed level
LevelIdx  out  4  output order index, 0 = first (highest-frequency) level
Done  out  1  one-cycle pulse after the last level handshake, or after Start with TotalCoeff=0

Behaviour:
- Reset: state IDLE; Busy, CodeReady, LevelValid, Done = 0; LevelOut, LevelIdx, SuffixBits = 0; suffixLength = 0.
- States: IDLE, T1, REQ, CALC, OUT, FIN.
- IDLE: on Start, latch the inputs and clear idx.
  - TotalCoeff = 0 -> FIN.
  - TrailingOnes > 0 -> T1.
  - Otherwise -> REQ.
  - suffixLength init = 1 if TotalCoeff > 10 and TrailingOnes < 3, else 0.
- T1: LevelValid = 1, LevelOut = T1Signs[idx] ? -1 : +1. On LevelValid&LevelReady, idx++.
  - When idx reaches TrailingOnes-1: go to FIN if TotalCoeff == TrailingOnes, else REQ.
- REQ: CodeReady = 1. SuffixBits is combinational from LevelPrefix and suffixLength:
  - 4 if prefix = 14 and suffixLength = 0.
  - 12 if prefix = 15.
  - suffixLength otherwise.
  - On CodeValid&CodeReady, register prefix/suffix -> CALC.
- CALC (one cycle), 14-bit unsigned levelCode:
  - levelCode = (prefix << suffixLength) + suffix.
  - +15 if prefix = 15 and suffixLength = 0.
  - +2 if this is the first non-T1 level and TrailingOnes < 3.
  - Level = even ? (levelCode+2)>>1 : -((levelCode+1)>>1), sign-extended/truncated to LEVEL_W.
  - Register LevelOut -> OUT.
  - Latency: code handshake to LevelValid = 2 cycles.
- suffixLength update (in CALC, after level computed):
  - If 0, set to 1.
  - Then, if |level| > (3 << (suffixLength-1)) and suffixLength < SUFFIX_MAX, increment. This compare uses the updated value.
- OUT: hold LevelValid and LevelOut stable until LevelReady, then idx++.
  - Go to FIN if idx+1 = TotalCoeff, else REQ.
- FIN: Done = 1 for one cycle, Busy = 0 -> IDLE.
- Backpressure: LevelOut, LevelIdx and LevelValid are held with no drop; CodeReady = 0 outside REQ.
- Start while Busy: ignored.
- Flush has priority over every transition. Pending outputs are dropped, no Done is issued, and suffixLength is cleared.
- TotalCoeff > MAX_COEFF is clamped to MAX_COEFF.
- TrailingOnes > TotalCoeff is treated as TotalCoeff.
- Async reset mid-block returns everything to reset values immediately.

Decomposition:
- Package cavlc_pkg: state enum, SUFFIX_MAX default, level_code_t (14-bit), constants ESC_PREFIX = 14, 15.
- Sub-module cavlc_level_calc (combinational): prefix, suffix, suffixLength, first-flag and T1<3 in; level and next suffixLength out. This lets the arithmetic be unit-tested exhaustively.

Test Plan:
- Start TotalCoeff=3, TrailingOnes=3, T1Signs=3'b010, LevelReady=1 -> levels +1,-1,+1 at idx 0..2, Done, no CodeReady.
- TotalCoeff=1, TrailingOnes=0, prefix=0, suffix=0 -> SuffixBits=0, levelCode=2, LevelOut=+2; then prefix=1 -> levelCode 3 -> -2 (second block).
- TotalCoeff=2, TrailingOnes=1, prefix=14, sl=0, suffix=4'b0101 -> SuffixBits=4, levelCode=14+5+2=21 -> LevelOut=-11, suffixLength -> 2.
- TotalCoeff=12, TrailingOnes=0, prefix=15, suffix=12'd100 -> sl init 1, SuffixBits=12, levelCode=(15<<1)+100+2=132 -> LevelOut=+67.
- Hold LevelReady=0 for 5 cycles in OUT -> LevelOut stable, no CodeReady; release -> single handshake.
- Flush mid-REQ, then Start TotalCoeff=0 -> no Done for aborted block; Done one cycle after Start, LevelValid never asserted.
